// File: rtl/dispatch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_buffer
// Description : In-order circular dispatch FIFO between decode and ROB/RS.
//               Optional same-cycle empty-buffer bypass: DISPATCH_BYPASS_EN.
// Revision    : 1.0  initial release
// ============================================================================
module dispatch_buffer #(
    parameter int PKT_W = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [PKT_W-1:0]         in_packet,
    output logic                     in_ready,
    input  logic [1:0]               rob_dp_available,
    input  logic                     rs_available,
    input  logic                     squash,
    output logic [PKT_W-1:0]         dp_packet,
    output logic [1:0]               dp_rob_available,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);

    localparam logic [1:0] c_RUN   = 2'd0;
    localparam logic [1:0] c_FLUSH = 2'd1;
    localparam logic [1:0] c_STALL = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [PKT_W-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic w_active;
    logic w_grant;
    logic w_fire;
    logic w_push;
    logic w_bypass;
    logic w_empty;

    assign w_empty = (r_count == '0);
    // Downstream handshake is independent of occupancy; squash vetoes any dispatch.
    assign w_grant = (rob_dp_available != 2'b00) & rs_available & ~squash;

`ifdef DISPATCH_BYPASS_EN
    assign w_bypass = (r_state == c_RUN) & w_empty & in_valid & w_grant;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_fire = w_active & ~w_empty & w_grant;
    assign w_push = in_valid & in_ready & ~squash & ~w_bypass;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_RUN: begin
                if (squash) begin
                    w_state_nxt = c_FLUSH;
                end else if (~w_empty & (rob_dp_available == 2'b00)) begin
                    w_state_nxt = c_STALL;
                end
            end
            c_STALL: begin
                if (squash) begin
                    w_state_nxt = c_FLUSH;
                end else if (w_fire) begin
                    w_state_nxt = c_RUN;
                end
            end
            c_FLUSH: w_state_nxt = c_RUN;
            default: w_state_nxt = c_RUN;
        endcase
    end

    // Output logic: STALL is informational and behaves like RUN.
    always_comb begin
        w_active = 1'b0;
        in_ready = 1'b0;
        case (r_state)
            c_RUN, c_STALL: begin
                w_active = 1'b1;
                in_ready = (r_count < c_FULL);
            end
            default: begin
                w_active = 1'b0;
                in_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (squash) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= in_packet;
                r_tail        <= r_tail + c_PTR_ONE;
            end
            if (w_fire) begin
                r_head <= r_head + c_PTR_ONE;
            end
            case ({w_push, w_fire})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        dp_packet = '0;
        if (w_fire) begin
            dp_packet = r_mem[r_head];
        end else if (w_bypass) begin
            dp_packet = in_packet;
        end
    end

    // Only 00 or 01 is ever driven; the ROB decodes dispatch as the XOR of both bits.
    assign dp_rob_available = {1'b0, w_fire | w_bypass};
    assign count            = r_count;

endmodule
`default_nettype wire

// File: tb/tb_dispatch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispatch_buffer
// Description : Directed self-checking bench for dispatch_buffer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dispatch_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_packet;
    logic        in_ready;
    logic [1:0]  rob_dp_available;
    logic        rs_available;
    logic        squash;
    logic [63:0] dp_packet;
    logic [1:0]  dp_rob_available;
    logic [3:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    dispatch_buffer #(.PKT_W(64), .DEPTH(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_packet        (in_packet),
        .in_ready         (in_ready),
        .rob_dp_available (rob_dp_available),
        .rs_available     (rs_available),
        .squash           (squash),
        .dp_packet        (dp_packet),
        .dp_rob_available (dp_rob_available),
        .count            (count)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] pk(input int n);
        return {32'hC0DE_0000 | 32'(n), 32'h1234_0000 + 32'(n)};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] p, input logic [1:0] rob,
                         input logic rs, input logic sq);
        in_valid         = v;
        in_packet        = p;
        rob_dp_available = rob;
        rs_available     = rs;
        squash           = sq;
    endtask

    task automatic do_reset();
        drive(1'b0, 64'd0, 2'b00, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b1, pk(99), 2'b00, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        #1;
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (dp_packet !== 64'd0) begin n_err++; $display("FAIL reset_dp_packet got=%h exp=0", dp_packet); end
        n_cmp++; if (dp_rob_available !== 2'b00) begin n_err++; $display("FAIL reset_dp_rob got=%b exp=00", dp_rob_available); end
        drive(1'b0, 64'd0, 2'b00, 1'b0, 1'b0);
        step();
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [63:0] exp_p;
        logic        exp_v;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(i < 3, (i < 3) ? pk(i + 1) : 64'd0, 2'b10, 1'b1, 1'b0);
            #1;
`ifdef DISPATCH_BYPASS_EN
            exp_v = (i < 3);
            exp_p = exp_v ? pk(i + 1) : 64'd0;
`else
            exp_v = (i >= 1) && (i <= 3);
            exp_p = exp_v ? pk(i) : 64'd0;
`endif
            n_cmp++; if (dp_rob_available !== {1'b0, exp_v}) begin n_err++; $display("FAIL basic_dp_rob[%0d] got=%b exp=%b", i, dp_rob_available, {1'b0, exp_v}); end
            n_cmp++; if (dp_packet !== exp_p) begin n_err++; $display("FAIL basic_dp_packet[%0d] got=%h exp=%h", i, dp_packet, exp_p); end
            step();
        end
        drive(1'b0, 64'd0, 2'b10, 1'b1, 1'b0);
        #1;
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL basic_count_end got=%0d exp=0", count); end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, pk(10 + i), 2'b00, 1'b1, 1'b0);
            step();
        end
        drive(1'b1, pk(50), 2'b00, 1'b1, 1'b0);
        #1;
        n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL stall_count got=%0d exp=8", count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
        n_cmp++; if (dut.r_state !== 2'd2) begin n_err++; $display("FAIL stall_state got=%0d exp=2", dut.r_state); end
        n_cmp++; if (dp_rob_available !== 2'b00) begin n_err++; $display("FAIL stall_no_fire got=%b exp=00", dp_rob_available); end
        step();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 64'd0, 2'b01, 1'b1, 1'b0);
            #1;
            n_cmp++; if (dp_rob_available !== 2'b01) begin n_err++; $display("FAIL stall_release_rob[%0d] got=%b exp=01", i, dp_rob_available); end
            n_cmp++; if (dp_packet !== pk(10 + i)) begin n_err++; $display("FAIL stall_release_pkt[%0d] got=%h exp=%h", i, dp_packet, pk(10 + i)); end
            step();
        end
        #1;
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL stall_drained got=%0d exp=0", count); end
        n_cmp++; if (dut.r_state !== 2'd0) begin n_err++; $display("FAIL stall_back_run got=%0d exp=0", dut.r_state); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] q[$];
        int          mcount;
        logic        exp_ready;
        logic        exp_fire;
        logic [63:0] exp_p;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, pk(100 + i), 2'b00, 1'b1, 1'b0);
            q.push_back(pk(100 + i));
            step();
        end
        mcount = 8;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, pk(200 + i), 2'b10, 1'b1, 1'b0);
            #1;
            exp_ready = (mcount < 8);
            exp_fire  = (mcount != 0);
            exp_p     = exp_fire ? q[0] : 64'd0;
            n_cmp++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL b2b_in_ready[%0d] got=%b exp=%b", i, in_ready, exp_ready); end
            n_cmp++; if (dp_packet !== exp_p) begin n_err++; $display("FAIL b2b_pkt[%0d] got=%h exp=%h", i, dp_packet, exp_p); end
            n_cmp++; if (count !== 4'(mcount) || mcount < 7) begin n_err++; $display("FAIL b2b_count[%0d] got=%0d exp=%0d", i, count, mcount); end
            if (exp_fire) begin
                void'(q.pop_front());
                mcount--;
            end
            if (exp_ready) begin
                q.push_back(pk(200 + i));
                mcount++;
            end
            step();
        end
    endtask

    task automatic test_squash();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, pk(300 + i), 2'b00, 1'b1, 1'b0);
            step();
        end
        drive(1'b1, pk(400), 2'b10, 1'b1, 1'b1);
        #1;
        n_cmp++; if (count !== 4'd5) begin n_err++; $display("FAIL squash_pre_count got=%0d exp=5", count); end
        n_cmp++; if (dp_rob_available !== 2'b00) begin n_err++; $display("FAIL squash_no_fire got=%b exp=00", dp_rob_available); end
        step();
        drive(1'b1, pk(401), 2'b10, 1'b1, 1'b0);
        #1;
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL flush_count got=%0d exp=0", count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        n_cmp++; if (dp_rob_available !== 2'b00) begin n_err++; $display("FAIL flush_no_fire got=%b exp=00", dp_rob_available); end
        step();
        drive(1'b0, 64'd0, 2'b10, 1'b1, 1'b0);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_flush_in_ready got=%b exp=1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (dp_rob_available !== 2'b00 || count !== 4'd0) begin n_err++; $display("FAIL post_flush_idle[%0d] got rob=%b count=%0d exp rob=00 count=0", i, dp_rob_available, count); end
            step();
        end
    endtask

    task automatic test_rs_block();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pk(500 + i), 2'b00, 1'b1, 1'b0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 64'd0, 2'b10, 1'b0, 1'b0);
            #1;
            n_cmp++; if (dp_rob_available !== 2'b00) begin n_err++; $display("FAIL rs_block_rob[%0d] got=%b exp=00", i, dp_rob_available); end
            n_cmp++; if (dp_packet !== 64'd0) begin n_err++; $display("FAIL rs_block_pkt[%0d] got=%h exp=0", i, dp_packet); end
            n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL rs_block_count[%0d] got=%0d exp=3", i, count); end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 64'd0, 2'b10, 1'b1, 1'b0);
            #1;
            n_cmp++; if (dp_rob_available !== 2'b01 || dp_packet !== pk(500 + i)) begin n_err++; $display("FAIL rs_resume[%0d] got rob=%b pkt=%h exp rob=01 pkt=%h", i, dp_rob_available, dp_packet, pk(500 + i)); end
            step();
        end
    endtask

    task automatic test_bypass();
        do_reset();
        drive(1'b1, pk(777), 2'b10, 1'b1, 1'b0);
        #1;
`ifdef DISPATCH_BYPASS_EN
        n_cmp++; if (dp_rob_available !== 2'b01 || dp_packet !== pk(777)) begin n_err++; $display("FAIL bypass_same_cycle got rob=%b pkt=%h exp rob=01 pkt=%h", dp_rob_available, dp_packet, pk(777)); end
        step();
        drive(1'b0, 64'd0, 2'b10, 1'b1, 1'b0);
        #1;
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL bypass_count got=%0d exp=0", count); end
`else
        n_cmp++; if (dp_rob_available !== 2'b00 || dp_packet !== 64'd0) begin n_err++; $display("FAIL nobypass_same_cycle got rob=%b pkt=%h exp rob=00 pkt=0", dp_rob_available, dp_packet); end
        step();
        drive(1'b0, 64'd0, 2'b10, 1'b1, 1'b0);
        #1;
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL nobypass_count got=%0d exp=1", count); end
        n_cmp++; if (dp_rob_available !== 2'b01 || dp_packet !== pk(777)) begin n_err++; $display("FAIL nobypass_next_cycle got rob=%b pkt=%h exp rob=01 pkt=%h", dp_rob_available, dp_packet, pk(777)); end
`endif
        step();
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 64'd0, 2'b00, 1'b0, 1'b0);
        step();
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_squash();
        test_rs_block();
        test_bypass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
